// File: rtl/alu_control_unit.sv
// Registered ALU control decoder: maps the main-control ALUOp class and the
// R-type funct field to a 4-bit ALU operation select plus an illegal flag.
module alu_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ALUOp,
    input  logic [5:0] func,
    output logic [3:0] ALUCtl,
    output logic       illegal
);

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_ADDU    = 4'b0011;
    localparam logic [3:0] CTL_SLL     = 4'b0100;
    localparam logic [3:0] CTL_SRL     = 4'b0101;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_SUBU    = 4'b1000;
    localparam logic [3:0] CTL_SLTU    = 4'b1001;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_INVALID = 4'b1111;

    logic [3:0] ctl_next;
    logic       ill_next;

    // Unmatched selectors (including X/Z bits) fall to the INVALID default,
    // and func is only examined in the R-type branch.
    always_comb begin
        ctl_next = CTL_INVALID;
        ill_next = 1'b1;
        case (ALUOp)
            3'b000: begin ctl_next = CTL_ADD; ill_next = 1'b0; end
            3'b001: begin ctl_next = CTL_SUB; ill_next = 1'b0; end
            3'b100: begin ctl_next = CTL_AND; ill_next = 1'b0; end
            3'b101: begin ctl_next = CTL_OR;  ill_next = 1'b0; end
            3'b110: begin ctl_next = CTL_SLT; ill_next = 1'b0; end
            3'b010: begin
                ill_next = 1'b0;
                case (func)
                    6'b100100: ctl_next = CTL_AND;
                    6'b100000: ctl_next = CTL_ADD;
                    6'b100001: ctl_next = CTL_ADDU;
                    6'b100101: ctl_next = CTL_OR;
                    6'b100111: ctl_next = CTL_NOR;
                    6'b100010: ctl_next = CTL_SUB;
                    6'b100011: ctl_next = CTL_SUBU;
                    6'b101010: ctl_next = CTL_SLT;
                    6'b101001: ctl_next = CTL_SLTU;
                    6'b101011: ctl_next = CTL_SLTU;
                    6'b000000: ctl_next = CTL_SLL;
                    6'b000010: ctl_next = CTL_SRL;
                    default: begin
                        ctl_next = CTL_INVALID;
                        ill_next = 1'b1;
                    end
                endcase
            end
            default: begin
                ctl_next = CTL_INVALID;
                ill_next = 1'b1;
            end
        endcase
    end

    // Reset parks the select at INVALID without raising an exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUCtl  <= CTL_INVALID;
            illegal <= 1'b0;
        end else begin
            ALUCtl  <= ctl_next;
            illegal <= ill_next;
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed-vector bench for alu_control_unit: decode table, latency,
// back-to-back updates and asynchronous mid-cycle reset.
module tb_alu_control_unit;

    logic       clk;
    logic       reset;
    logic [2:0] ALUOp;
    logic [5:0] func;
    logic [3:0] ALUCtl;
    logic       illegal;

    int n_vectors;
    int miscompares;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] exp_ctl;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[$];
    logic [4:0] exp_q[$];

    alu_control_unit dut (
        .clk     (clk),
        .reset   (reset),
        .ALUOp   (ALUOp),
        .func    (func),
        .ALUCtl  (ALUCtl),
        .illegal (illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp_ctl, input logic exp_ill);
        n_vectors++;
        if (ALUCtl !== exp_ctl || illegal !== exp_ill) begin
            miscompares++;
            $display("FAIL %s: got ALUCtl=%b illegal=%b, expected ALUCtl=%b illegal=%b",
                     name, ALUCtl, illegal, exp_ctl, exp_ill);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] fn);
        ALUOp = op;
        func  = fn;
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [5:0] fn,
                           input logic [3:0] c, input logic i);
        vec_t v;
        v.op = op; v.fn = fn; v.exp_ctl = c; v.exp_ill = i;
        vecs.push_back(v);
    endtask

    initial begin
        logic [4:0] e;
        n_vectors   = 0;
        miscompares = 0;
        reset = 1'b0;
        drive(3'b000, 6'b0);

        // non-R-type classes, func is don't-care
        add_vec(3'b000, 6'bxxxxxx, 4'b0010, 1'b0);
        add_vec(3'b001, 6'bxxxxxx, 4'b0110, 1'b0);
        add_vec(3'b100, 6'b111111, 4'b0000, 1'b0);
        add_vec(3'b101, 6'b100000, 4'b0001, 1'b0);
        add_vec(3'b110, 6'b000010, 4'b0111, 1'b0);
        // R-type func sweep
        add_vec(3'b010, 6'b100100, 4'b0000, 1'b0);
        add_vec(3'b010, 6'b100000, 4'b0010, 1'b0);
        add_vec(3'b010, 6'b100001, 4'b0011, 1'b0);
        add_vec(3'b010, 6'b100101, 4'b0001, 1'b0);
        add_vec(3'b010, 6'b100111, 4'b1100, 1'b0);
        add_vec(3'b010, 6'b100010, 4'b0110, 1'b0);
        add_vec(3'b010, 6'b100011, 4'b1000, 1'b0);
        add_vec(3'b010, 6'b101010, 4'b0111, 1'b0);
        add_vec(3'b010, 6'b101001, 4'b1001, 1'b0);
        add_vec(3'b010, 6'b101011, 4'b1001, 1'b0);
        add_vec(3'b010, 6'b000000, 4'b0100, 1'b0);
        add_vec(3'b010, 6'b000010, 4'b0101, 1'b0);
        // unsupported encodings
        add_vec(3'b010, 6'b111111, 4'b1111, 1'b1);
        add_vec(3'b010, 6'b101000, 4'b1111, 1'b1);
        add_vec(3'b010, 6'b000001, 4'b1111, 1'b1);
        add_vec(3'b011, 6'b100000, 4'b1111, 1'b1);
        add_vec(3'b111, 6'b100000, 4'b1111, 1'b1);
        // valid after illegal: flag must drop
        add_vec(3'b000, 6'b111111, 4'b0010, 1'b0);

        // asynchronous reset asserted before any clock edge
        #2 reset = 1'b1;
        #1 check("reset_async_initial", 4'b1111, 1'b0);
        @(posedge clk); #1 check("reset_held_edge", 4'b1111, 1'b0);
        @(negedge clk); reset = 1'b0;
        drive(3'b001, 6'b0);
        #1 check("reset_release_no_edge", 4'b1111, 1'b0);
        @(posedge clk); #1 check("first_edge_after_release", 4'b0110, 1'b0);

        // table applied back-to-back, one new vector per cycle
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].op, vecs[k].fn);
            exp_q.push_back({vecs[k].exp_ill, vecs[k].exp_ctl});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d_op%b_fn%b", k, vecs[k].op, vecs[k].fn), e[3:0], e[4]);
        end

        // inputs changing between edges must not reach the outputs early
        @(negedge clk); drive(3'b010, 6'b100111);
        @(posedge clk); #1 check("latency_base", 4'b1100, 1'b0);
        #2 drive(3'b101, 6'b0);
        #1 check("latency_midcycle_hold", 4'b1100, 1'b0);
        @(negedge clk); #1 check("latency_negedge_hold", 4'b1100, 1'b0);
        @(posedge clk); #1 check("latency_update", 4'b0001, 1'b0);

        // mid-cycle reset while illegal is set clears both outputs at once
        @(negedge clk); drive(3'b111, 6'b0);
        @(posedge clk); #1 check("pre_reset_illegal", 4'b1111, 1'b1);
        #2 reset = 1'b1;
        #1 check("reset_midcycle", 4'b1111, 1'b0);
        drive(3'b010, 6'b100001);
        @(posedge clk); #1 check("reset_midcycle_held", 4'b1111, 1'b0);
        @(negedge clk); reset = 1'b0;
        #1 check("reset_release_wait", 4'b1111, 1'b0);
        @(posedge clk); #1 check("after_midcycle_reset", 4'b0011, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

endmodule
